regreg_alu_fsm: RTL and testbench

- Control FSM for register-to-register instructions on the shared 16-bit bus datapath: four general registers Ri1..Ri4, ALU operand registers ALUreg1/ALUreg2, ALU result register ALUregO, and a tristate ALU output driver.
- Companion to the immediate-form FSM; both drive the same control lines, and the top level selects which one is active.
- Takes a START pulse with opcode and register fields, then sequences the bus transfers.
- Pulses PCinc and finish on completion.

---
 rtl/regreg_alu_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_regreg_alu_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regreg_alu_fsm.sv
// regreg_alu_fsm: control sequencer for register-to-register instructions on
// the shared 16-bit bus (Ri1..Ri4, ALUreg1/2, ALUregO, ALU tristate driver).
// Optional build macro RRFSM_ILLEGAL_ERR_EN: adds an err output and routes
// illegal opcodes through an ERR state instead of a NOP completion.
module regreg_alu_fsm #(
  parameter logic [3:0]  MOV_OPCODE = 4'b1111,
  parameter int unsigned RS_W       = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [3:0]      OPCODE,
  input  logic [RS_W-1:0] rs1,
  input  logic [RS_W-1:0] rs2,
  input  logic [RS_W-1:0] rd,
  output logic            Ri1Out,
  output logic            Ri2Out,
  output logic            Ri3Out,
  output logic            Ri4Out,
  output logic            Ri1In,
  output logic            Ri2In,
  output logic            Ri3In,
  output logic            Ri4In,
  output logic            ALUreg1,
  output logic            ALUreg2,
  output logic            ALUregO,
  output logic            ALUtri,
  output logic [2:0]      ALUop,
  output logic            PCinc,
  output logic            finish,
  output logic            busy
`ifdef RRFSM_ILLEGAL_ERR_EN
  ,
  output logic            err
`endif
);

  localparam int unsigned NREG    = 2 ** RS_W;
  localparam int unsigned ALUOP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD1  = 3'd1,
    S_LD2  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4,
    S_MOV  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [ALUOP_W-1:0]   aluop_q, aluop_d;
  logic [RS_W-1:0]      rs1_q, rs1_d;
  logic [RS_W-1:0]      rs2_q, rs2_d;
  logic [RS_W-1:0]      rd_q, rd_d;

  // Registered outputs; next values are the Moore decode of the next state.
  logic [NREG-1:0]      ri_out_q, ri_out_d;
  logic [NREG-1:0]      ri_in_q, ri_in_d;
  logic                 alu1_q, alu1_d;
  logic                 alu2_q, alu2_d;
  logic                 aluo_q, aluo_d;
  logic                 alutri_q, alutri_d;
  logic [ALUOP_W-1:0]   op_q, op_d;
  logic                 pcinc_q, pcinc_d;
  logic                 finish_q, finish_d;
  logic                 busy_q, busy_d;
`ifdef RRFSM_ILLEGAL_ERR_EN
  logic                 err_q, err_d;
`endif

  // Next-state, field latching, and decode of the next state into outputs.
  always_comb begin
    state_d  = state_q;
    aluop_d  = aluop_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ri_out_d = '0;
    ri_in_d  = '0;
    alu1_d   = 1'b0;
    alu2_d   = 1'b0;
    aluo_d   = 1'b0;
    alutri_d = 1'b0;
    op_d     = '0;
    pcinc_d  = 1'b0;
    finish_d = 1'b0;
    busy_d   = 1'b0;
`ifdef RRFSM_ILLEGAL_ERR_EN
    err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (START) begin
          aluop_d = OPCODE[2:0];
          rs1_d   = rs1;
          rs2_d   = rs2;
          rd_d    = rd;
          if (!OPCODE[3]) begin
            state_d = S_LD1;
          end else if (OPCODE == MOV_OPCODE) begin
            state_d = S_MOV;
          end else begin
`ifdef RRFSM_ILLEGAL_ERR_EN
            state_d = S_ERR;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_LD1:   state_d = S_LD2;
      S_LD2:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_MOV:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_LD1: begin
        ri_out_d[rs1_d] = 1'b1;
        alu1_d          = 1'b1;
      end
      S_LD2: begin
        ri_out_d[rs2_d] = 1'b1;
        alu2_d          = 1'b1;
      end
      S_EXE: begin
        op_d   = aluop_d;
        aluo_d = 1'b1;
      end
      S_WB: begin
        alutri_d       = 1'b1;
        ri_in_d[rd_d]  = 1'b1;
      end
      S_MOV: begin
        ri_out_d[rs1_d] = 1'b1;
        ri_in_d[rd_d]   = 1'b1;
      end
      S_DONE: begin
        finish_d = 1'b1;
        pcinc_d  = 1'b1;
      end
      S_ERR: begin
`ifdef RRFSM_ILLEGAL_ERR_EN
        err_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // State, latched fields and output registers; reset aborts any instruction.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      aluop_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      ri_out_q <= '0;
      ri_in_q  <= '0;
      alu1_q   <= 1'b0;
      alu2_q   <= 1'b0;
      aluo_q   <= 1'b0;
      alutri_q <= 1'b0;
      op_q     <= '0;
      pcinc_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef RRFSM_ILLEGAL_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aluop_q  <= aluop_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ri_out_q <= ri_out_d;
      ri_in_q  <= ri_in_d;
      alu1_q   <= alu1_d;
      alu2_q   <= alu2_d;
      aluo_q   <= aluo_d;
      alutri_q <= alutri_d;
      op_q     <= op_d;
      pcinc_q  <= pcinc_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
`ifdef RRFSM_ILLEGAL_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign Ri1Out  = ri_out_q[0];
  assign Ri2Out  = ri_out_q[1];
  assign Ri3Out  = ri_out_q[2];
  assign Ri4Out  = ri_out_q[3];
  assign Ri1In   = ri_in_q[0];
  assign Ri2In   = ri_in_q[1];
  assign Ri3In   = ri_in_q[2];
  assign Ri4In   = ri_in_q[3];
  assign ALUreg1 = alu1_q;
  assign ALUreg2 = alu2_q;
  assign ALUregO = aluo_q;
  assign ALUtri  = alutri_q;
  assign ALUop   = op_q;
  assign PCinc   = pcinc_q;
  assign finish  = finish_q;
  assign busy    = busy_q;
`ifdef RRFSM_ILLEGAL_ERR_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_regreg_alu_fsm.sv
// Directed bench for regreg_alu_fsm; outputs sampled on the falling edge.
module tb_regreg_alu_fsm;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [3:0] OPCODE;
  logic [1:0] rs1, rs2, rd;
  logic       Ri1Out, Ri2Out, Ri3Out, Ri4Out;
  logic       Ri1In, Ri2In, Ri3In, Ri4In;
  logic       ALUreg1, ALUreg2, ALUregO, ALUtri;
  logic [2:0] ALUop;
  logic       PCinc, finish, busy;
`ifdef RRFSM_ILLEGAL_ERR_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;
  logic inv_en = 1'b0;

  regreg_alu_fsm dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .Ri1Out(Ri1Out), .Ri2Out(Ri2Out), .Ri3Out(Ri3Out), .Ri4Out(Ri4Out),
    .Ri1In(Ri1In), .Ri2In(Ri2In), .Ri3In(Ri3In), .Ri4In(Ri4In),
    .ALUreg1(ALUreg1), .ALUreg2(ALUreg2), .ALUregO(ALUregO), .ALUtri(ALUtri),
    .ALUop(ALUop), .PCinc(PCinc), .finish(finish), .busy(busy)
`ifdef RRFSM_ILLEGAL_ERR_EN
    , .err(err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {RiOut[4:1], RiIn[4:1], ALUreg1, ALUreg2, ALUregO, ALUtri, ALUop, PCinc, finish, busy}
  logic [17:0] obs;
  assign obs = {Ri4Out, Ri3Out, Ri2Out, Ri1Out, Ri4In, Ri3In, Ri2In, Ri1In,
                ALUreg1, ALUreg2, ALUregO, ALUtri, ALUop, PCinc, finish, busy};

  // ctl = {ALUreg1, ALUreg2, ALUregO, ALUtri}; fl = {PCinc, finish, busy}
  function automatic logic [17:0] ev(input logic [3:0] ro, input logic [3:0] ri,
                                     input logic [3:0] ctl, input logic [2:0] op,
                                     input logic [2:0] fl);
    return {ro, ri, ctl, op, fl};
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [17:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, e);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d);
    OPCODE = op; rs1 = a; rs2 = b; rd = d; START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // At most one bus driver in any cycle.
  always @(negedge CLK) begin
    if (inv_en) begin
      total++;
      assert ($countones({Ri1Out, Ri2Out, Ri3Out, Ri4Out, ALUtri}) <= 1) else begin
        bad++;
        $error("FAIL bus_onehot observed=%b expected=at_most_one",
               {Ri1Out, Ri2Out, Ri3Out, Ri4Out, ALUtri});
      end
    end
  end

  localparam logic [17:0] ZERO = 18'h0;

  initial begin
    RESET = 1'b1; START = 1'b0; OPCODE = 4'h0; rs1 = '0; rs2 = '0; rd = '0;
    @(negedge CLK);
    step();
    inv_en = 1'b1;
    chk("reset_hold", ZERO);
`ifdef RRFSM_ILLEGAL_ERR_EN
    total++;
    assert (err === 1'b0) else begin bad++; $error("FAIL reset_err observed=%b expected=0", err); end
`endif
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_idle", ZERO);
    end

    // ALU op 0010, rs1=0 rs2=2 rd=3
    issue(4'b0010, 2'd0, 2'd2, 2'd3);
    chk("alu_ld1", ev(4'b0001, 4'b0000, 4'b1000, 3'b000, 3'b001));
    step(); chk("alu_ld2", ev(4'b0100, 4'b0000, 4'b0100, 3'b000, 3'b001));
    step(); chk("alu_exe", ev(4'b0000, 4'b0000, 4'b0010, 3'b010, 3'b001));
    step(); chk("alu_wb",  ev(4'b0000, 4'b1000, 4'b0001, 3'b000, 3'b001));
    step(); chk("alu_done", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    step(); chk("alu_idle", ZERO);

    // MOV rs1=1 rd=0; START held through DONE is ignored, then taken in IDLE
    issue(4'b1111, 2'd1, 2'd3, 2'd0);
    chk("mov_c1", ev(4'b0010, 4'b0001, 4'b0000, 3'b000, 3'b001));
    step(); chk("mov_done", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    OPCODE = 4'b1111; rs1 = 2'd3; rd = 2'd3; START = 1'b1;
    step(); chk("start_in_done_ignored", ZERO);
    step(); START = 1'b0;
    chk("mov_same_c1", ev(4'b1000, 4'b1000, 4'b0000, 3'b000, 3'b001));
    step(); chk("mov_same_done", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    step(); chk("mov_same_idle", ZERO);

    // ALU op with rs1==rs2 and a START during EXE that must be ignored
    issue(4'b0010, 2'd1, 2'd1, 2'd2);
    chk("busy_ld1", ev(4'b0010, 4'b0000, 4'b1000, 3'b000, 3'b001));
    step(); chk("busy_ld2", ev(4'b0010, 4'b0000, 4'b0100, 3'b000, 3'b001));
    step(); chk("busy_exe", ev(4'b0000, 4'b0000, 4'b0010, 3'b010, 3'b001));
    OPCODE = 4'b0101; rs1 = 2'd3; rs2 = 2'd3; rd = 2'd0; START = 1'b1;
    step(); START = 1'b0;
    chk("busy_wb", ev(4'b0000, 4'b0100, 4'b0001, 3'b000, 3'b001));
    step(); chk("busy_done", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    step(); chk("busy_no_queue1", ZERO);
    step(); chk("busy_no_queue2", ZERO);

    // Reset during LD2 aborts; next instruction completes normally
    issue(4'b0011, 2'd2, 2'd3, 2'd1);
    chk("abort_ld1", ev(4'b0100, 4'b0000, 4'b1000, 3'b000, 3'b001));
    step(); chk("abort_ld2", ev(4'b1000, 4'b0000, 4'b0100, 3'b000, 3'b001));
    RESET = 1'b1;
    step(); chk("abort_reset", ZERO);
    RESET = 1'b0;
    step(); chk("abort_after", ZERO);
    issue(4'b0001, 2'd3, 2'd0, 2'd0);
    chk("post_ld1", ev(4'b1000, 4'b0000, 4'b1000, 3'b000, 3'b001));
    step(); chk("post_ld2", ev(4'b0001, 4'b0000, 4'b0100, 3'b000, 3'b001));
    step(); chk("post_exe", ev(4'b0000, 4'b0000, 4'b0010, 3'b001, 3'b001));
    step(); chk("post_wb",  ev(4'b0000, 4'b0001, 4'b0001, 3'b000, 3'b001));
    step(); chk("post_done", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    step(); chk("post_idle", ZERO);

    // Illegal opcode
    issue(4'b1010, 2'd1, 2'd2, 2'd3);
`ifdef RRFSM_ILLEGAL_ERR_EN
    chk("illegal_c1", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b001));
    total++;
    assert (err === 1'b1) else begin bad++; $error("FAIL illegal_err observed=%b expected=1", err); end
    step(); chk("illegal_c2", ZERO);
    total++;
    assert (err === 1'b0) else begin bad++; $error("FAIL illegal_err_clear observed=%b expected=0", err); end
`else
    chk("illegal_c1", ev(4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b111));
    step(); chk("illegal_c2", ZERO);
`endif
    step(); chk("final_idle", ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
